mult_pipe_param: RTL and testbench

//  Parametrised, fully pipelined RV32M/RV64M-style multiplier for the M-extension execute path.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_pipe_stage.sv | 47 ++++
 rtl/mult_pipe_param.sv | 85 ++++++++
 tb/tb_mult_pipe_param.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: op encoding and operand-signedness helpers shared by the pipelined multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    function automatic logic is_signed_a(mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic is_signed_b(mul_op_e op);
        return op == MULH;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// mult_pipe_stage: one {valid, tag, data} register slice with advance/hold/flush control.
module mult_pipe_stage
    import mult_pkg::*;
#(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              adv_i,
    input  logic              in_valid_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              valid_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Payload only loads for a real op so bubbles don't toggle the wide data path.
    always_comb begin
        valid_d = flush_i ? 1'b0 : (adv_i ? in_valid_i : valid_q);
        tag_d   = (adv_i && in_valid_i) ? in_tag_i : tag_q;
        data_d  = (adv_i && in_valid_i) ? in_data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mult_pipe_param.sv
// mult_pipe_param: pipelined MUL/MULH/MULHSU/MULHU with valid/ready handshakes, tags and flush.
module mult_pipe_param
    import mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o
);

    mul_op_e            op;
    logic [2*WIDTH-1:0] a_x, b_x, prod;
    logic [WIDTH-1:0]   res;
    logic [STAGES-1:0]  vld, adv, vin;
    logic [TAG_W-1:0]   tin  [STAGES];
    logic [TAG_W-1:0]   tout [STAGES];
    logic [WIDTH-1:0]   din  [STAGES];
    logic [WIDTH-1:0]   dout [STAGES];

    assign op = mul_op_e'(op_sel_i);

    // Extending to 2*WIDTH and multiplying modulo 2^(2*WIDTH) yields the same low
    // 2*WIDTH bits as the signed (WIDTH+1)x(WIDTH+1) product.
    always_comb begin
        a_x  = {{WIDTH{is_signed_a(op) & a_i[WIDTH-1]}}, a_i};
        b_x  = {{WIDTH{is_signed_b(op) & b_i[WIDTH-1]}}, b_i};
        prod = a_x * b_x;
        res  = (op == MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~vld[STAGES-1] | out_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) adv[k] = ~vld[k] | adv[k+1];
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            if (g == 0) begin : g_head
                assign vin[g] = in_valid_i & ~flush_i;
                assign tin[g] = tag_i;
                assign din[g] = res;
            end else begin : g_body
                assign vin[g] = vld[g-1];
                assign tin[g] = tout[g-1];
                assign din[g] = dout[g-1];
            end
            mult_pipe_stage #(
                .TAG_W  (TAG_W),
                .DATA_W (WIDTH)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush_i    (flush_i),
                .adv_i      (adv[g]),
                .in_valid_i (vin[g]),
                .in_tag_i   (tin[g]),
                .in_data_i  (din[g]),
                .valid_o    (vld[g]),
                .tag_o      (tout[g]),
                .data_o     (dout[g])
            );
        end
    endgenerate

    assign in_ready_o  = adv[0];
    assign out_valid_o = vld[STAGES-1];
    assign result_o    = dout[STAGES-1];
    assign tag_o       = tout[STAGES-1];

endmodule

// File: tb/tb_mult_pipe_param.sv
// tb_mult_pipe_param: directed and randomized checks of mult_pipe_param against a queue-based model.
module tb_mult_pipe_param;

    localparam int W = 32;
    localparam int S = 3;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [1:0]   op_sel_i = 2'b00;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic [T-1:0] tag_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] result_o;
    logic [T-1:0] tag_o;

    mult_pipe_param #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_sel_i    (op_sel_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: exact product with plain 64-bit integer arithmetic.
    function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        sb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p = sa * sb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [T-1:0] tag;
        logic [W-1:0] res;
    } exp_t;

    exp_t         q[$];
    logic         hold = 1'b0;
    logic [W-1:0] h_res;
    logic [T-1:0] h_tag;

    // Scoreboard: every handshaked result must match the oldest accepted op.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) check("hold", {out_valid_o, tag_o, result_o}, {1'b1, h_tag, h_res});
            if (out_valid_o && out_ready_i) begin
                check("emit_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    check("emit", {tag_o, result_o}, {q[0].tag, q[0].res});
                    void'(q.pop_front());
                end
            end
            hold = out_valid_o && !out_ready_i && !flush_i;
            h_res = result_o;
            h_tag = tag_o;
            if (flush_i) q.delete();
            else if (in_valid_i && in_ready_o) q.push_back('{tag_i, model(op_sel_i, a_i, b_i)});
        end
    end

    task automatic run_one(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tg,
                           logic [31:0] exp, string nm);
        int n = 0;
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        op_sel_i = op;
        a_i = a;
        b_i = b;
        tag_i = tg;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) in_valid_i = 1'b0;
            @(negedge clk);
        end while (!out_valid_o && n < 20);
        check({nm, "_lat"}, n, 3);
        check({nm, "_res"}, result_o, exp);
        check({nm, "_tag"}, tag_o, tg);
    endtask

    logic [1:0]  op4 [6];
    logic [31:0] a4 [6];
    logic [31:0] b4 [6];
    int          nxt, acc;
    int          ftag[$];
    int          fcyc[$];
    logic [36:0] held;
    logic        seen;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        check("rst_valid", out_valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_ready", in_ready_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_one(2'b00, 32'd10, 32'd20, 5'd1, 32'd200, "mul");
        run_one(2'b01, 32'd1000, -32'sd500, 5'd2, 32'hFFFF_FFFF, "mulh_neg");
        run_one(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, "mulh_min");
        run_one(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, "mulhsu");
        run_one(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, "mulhu");

        // Back-pressure: fill the pipe, hold the head, then release.
        for (int i = 0; i < 6; i++) begin
            op4[i] = 2'($urandom);
            a4[i] = pick();
            b4[i] = pick();
        end
        nxt = 0;
        acc = 0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready_i = (c >= 7);
            in_valid_i = (nxt < 6);
            if (nxt < 6) begin
                op_sel_i = op4[nxt];
                a_i = a4[nxt];
                b_i = b4[nxt];
                tag_i = nxt[4:0];
            end
            @(negedge clk);
            if (c < 7 && acc == 3) check("bp_full_ready", in_ready_o, 0);
            if (c == 6) check("bp_accepts", acc, 3);
            if (c < 7 && out_valid_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    held = {tag_o, result_o};
                end else check("bp_stable", {tag_o, result_o}, held);
            end
            if (out_valid_o && out_ready_i) begin
                ftag.push_back(int'(tag_o));
                fcyc.push_back(c);
            end
            if (in_valid_i && in_ready_o) begin
                acc++;
                nxt++;
            end
        end
        check("bp_head_seen", seen, 1);
        check("bp_head_tag", held[36:32], 0);
        check("bp_count", ftag.size(), 6);
        for (int i = 0; i < ftag.size(); i++) begin
            check("bp_order", ftag[i], i);
            check("bp_rate", fcyc[i], fcyc[0] + i);
        end

        // Flush with a full pipe and a fourth op offered.
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            op_sel_i = 2'($urandom);
            a_i = pick();
            b_i = pick();
            tag_i = 5'(10 + i);
            @(posedge clk); #1;
        end
        tag_i = 5'd13;
        flush_i = 1'b1;
        @(negedge clk);
        check("fl_full_ready", in_ready_o, 0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        check("fl_cleared", out_valid_o, 0);
        out_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("fl_quiet", out_valid_o, 0);
        end
        // Flush into an empty pipe: ready still high, offered op dropped.
        @(posedge clk); #1;
        in_valid_i = 1'b1;
        tag_i = 5'd15;
        flush_i = 1'b1;
        @(negedge clk);
        check("fl_ready", in_ready_o, 1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("fl_drop", out_valid_o, 0);
        end
        run_one(2'b00, 32'd7, 32'd6, 5'd14, 32'd42, "post_flush");

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1;
            op_sel_i = 2'($urandom);
            a_i = pick();
            b_i = pick();
            tag_i = 5'(20 + i);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        check("pre_rst_valid", out_valid_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid_o, 0);
        check("arst_result", result_o, 0);
        check("arst_tag", tag_o, 0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready_o, 1);
        check("post_rst_valid", out_valid_o, 0);

        // Random traffic with back-pressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid_i = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 31) == 0);
            op_sel_i = 2'($urandom);
            a_i = pick();
            b_i = pick();
            tag_i = 5'($urandom);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_queue", q.size(), 0);
        check("drain_valid", out_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
